// File: rtl/sha256_stream_core_if.sv
// Block-stream bus between the padder/front-end and the SHA-256/224 core.
// The master side presents padded 512-bit blocks and receives the digest.
interface sha256_stream_core_if;
  logic         i_valid;
  logic         o_ready;
  logic [511:0] data_in;
  logic         i_first;
  logic         i_last;
  logic         i_mode;
  logic         o_busy;
  logic         o_done;
  logic [255:0] data_out;
  logic [7:0]   o_blk_cnt;

  modport master (
    output i_valid, data_in, i_first, i_last, i_mode,
    input  o_ready, o_busy, o_done, data_out, o_blk_cnt
  );

  modport slave (
    input  i_valid, data_in, i_first, i_last, i_mode,
    output o_ready, o_busy, o_done, data_out, o_blk_cnt
  );
endinterface

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 / SHA-224 compression engine.
// Takes pre-padded 512-bit blocks, chains the intermediate hash across blocks
// and evaluates ROUNDS_PER_CYCLE compression rounds per clock.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sha256_stream_core_if.slave bus
);

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Index 0 is the leftmost (most significant) word: H0 / working variable a.
  typedef logic [0:7][31:0] hash_t;
  typedef enum logic [2:0] {IDLE, ROUND, UPDATE, DONE, WAIT_NEXT} state_t;

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

  localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One SHA-256 round applied to the working variables a..h.
  function automatic hash_t sha_round(input hash_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

  state_t       state_reg, state_next;
  hash_t        h_reg, wk_reg, rnd_state;
  logic [31:0]  w_reg [0:15];
  logic [31:0]  w_ext [0:15+ROUNDS_PER_CYCLE];
  logic [5:0]   rnd_reg;
  logic         mode_reg, last_reg, done_reg;
  logic [255:0] dout_reg;
  logic [7:0]   cnt_reg;
  logic         accept, start_new, mode_sel;
  hash_t        iv_sel;

  assign bus.o_ready   = (state_reg == IDLE) || (state_reg == WAIT_NEXT);
  assign bus.o_busy    = (state_reg == ROUND) || (state_reg == UPDATE);
  assign bus.o_done    = done_reg;
  assign bus.data_out  = dout_reg;
  assign bus.o_blk_cnt = cnt_reg;

  // An accept in IDLE always opens a fresh message, whatever i_first says.
  assign accept    = bus.i_valid && bus.o_ready;
  assign start_new = (state_reg == IDLE) || bus.i_first;
  assign mode_sel  = SUPPORT_224 ? bus.i_mode : 1'b0;
  assign iv_sel    = mode_sel ? IV224 : IV256;

  // Schedule extension and the chain of rounds evaluated this cycle.
  // w_ext[0..15] is the current window; entries 16.. are the words that slide in.
  always_comb begin
    for (int j = 0; j < 16; j++) w_ext[j] = w_reg[j];
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
      w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
    rnd_state = wk_reg;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
      rnd_state = sha_round(rnd_state, K_ROM[rnd_reg + 6'(j)], w_ext[j]);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, WAIT_NEXT: if (accept) state_next = ROUND;
      ROUND:           if (rnd_reg == LAST_RND) state_next = UPDATE;
      UPDATE:          state_next = last_reg ? DONE : WAIT_NEXT;
      DONE:            state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // Datapath: block load, rounds, hash accumulation and digest capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg    <= '0;
      wk_reg   <= '0;
      for (int j = 0; j < 16; j++) w_reg[j] <= '0;
      rnd_reg  <= '0;
      mode_reg <= 1'b0;
      last_reg <= 1'b0;
      done_reg <= 1'b0;
      dout_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, WAIT_NEXT: begin
          if (accept) begin
            for (int j = 0; j < 16; j++) w_reg[j] <= bus.data_in[32*(15-j) +: 32];
            rnd_reg  <= '0;
            last_reg <= bus.i_last;
            if (start_new) begin
              h_reg    <= iv_sel;
              wk_reg   <= iv_sel;
              mode_reg <= mode_sel;
              cnt_reg  <= '0;
            end else begin
              wk_reg <= h_reg;
            end
          end
        end
        ROUND: begin
          wk_reg <= rnd_state;
          for (int j = 0; j < 16; j++) w_reg[j] <= w_ext[j+ROUNDS_PER_CYCLE];
          rnd_reg <= rnd_reg + RND_STEP;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wk_reg[i];
          if (cnt_reg != 8'hff) cnt_reg <= cnt_reg + 8'd1;
        end
        DONE: begin
          dout_reg <= mode_reg ? {h_reg[0:6], 32'h0} : h_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Self-checking bench for sha256_stream_core: one instance at 1 round/cycle
// and one at 4 rounds/cycle, checked against a textbook SHA-256 model.
module tb_sha256_stream_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int sel;  // 0 selects the 1-round instance, 1 the 4-round instance
  logic         drv_valid, drv_first, drv_last, drv_mode;
  logic [511:0] drv_data;

  sha256_stream_core_if bus1 ();
  sha256_stream_core_if bus4 ();

  assign bus1.i_valid = drv_valid && (sel == 0);
  assign bus1.data_in = drv_data;
  assign bus1.i_first = drv_first;
  assign bus1.i_last  = drv_last;
  assign bus1.i_mode  = drv_mode;
  assign bus4.i_valid = drv_valid && (sel == 1);
  assign bus4.data_in = drv_data;
  assign bus4.i_first = drv_first;
  assign bus4.i_last  = drv_last;
  assign bus4.i_mode  = drv_mode;

  sha256_stream_core #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sha256_stream_core #(.ROUNDS_PER_CYCLE(4), .SUPPORT_224(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  logic         m_ready, m_busy, m_done;
  logic [255:0] m_dout;
  logic [7:0]   m_cnt;
  always_comb begin
    if (sel == 0) begin
      m_ready = bus1.o_ready; m_busy = bus1.o_busy; m_done = bus1.o_done;
      m_dout  = bus1.data_out; m_cnt = bus1.o_blk_cnt;
    end else begin
      m_ready = bus4.o_ready; m_busy = bus4.o_busy; m_done = bus4.o_done;
      m_dout  = bus4.data_out; m_cnt = bus4.o_blk_cnt;
    end
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b3168581511_64f98fa7befa4fa4;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] BLK_TWO2  = 512'h1c0;
  localparam logic [255:0] DIG_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] DIG_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: one open message at a time.
  logic [255:0] mh;
  logic [255:0] last_digest;
  bit           mopen, mmode;
  int           mcnt;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic int rpc();
    return (sel == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    mopen = 1'b0; mmode = 1'b0; mcnt = 0; mh = '0; last_digest = '0;
  endtask

  task automatic model_accept(input logic [511:0] data, input logic first, input logic last, input logic mode);
    if (!mopen || first) begin
      mmode = mode;
      mh    = mode ? IV224 : IV256;
      mcnt  = 0;
    end
    mh = compress(mh, data);
    if (mcnt < 255) mcnt++;
    mopen = !last;
    if (last) last_digest = mmode ? {mh[255:32], 32'h0} : mh;
  endtask

  // Present one block (called just after a negedge with the core ready) and
  // follow it cycle by cycle to the point where the core is ready again.
  // With junk set, i_valid stays high with garbage while the core is not ready.
  task automatic send(input logic [511:0] data, input logic first, input logic last,
                      input logic mode, input bit junk);
    int lat;
    lat = 64 / rpc() + 2;
    check("pre_ready", m_ready, 1'b1);
    check("pre_dout", m_dout, last_digest);
    drv_valid = 1'b1; drv_data = data; drv_first = first; drv_last = last; drv_mode = mode;
    model_accept(data, first, last, mode);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        check("rnd_ready", m_ready, 1'b0);
        check("rnd_busy", m_busy, 1'b1);
        check("rnd_done", m_done, 1'b0);
      end else begin
        check("end_ready", m_ready, !last);
        check("end_busy", m_busy, 1'b0);
        check("end_done", m_done, 1'b0);
        check("end_cnt", m_cnt, mcnt);
      end
      if (junk && (k < lat || last)) begin
        drv_valid = 1'b1; drv_data = rand_block();
        drv_first = 1'($urandom); drv_last = 1'($urandom); drv_mode = 1'($urandom);
      end else begin
        drv_valid = 1'b0;
      end
    end
    @(negedge clk);
    drv_valid = 1'b0;
    check("post_done", m_done, last);
    check("post_ready", m_ready, 1'b1);
    if (last) check("post_dout", m_dout, last_digest);
    $display("tx rpc=%0d first=%0b last=%0b mode=%0b junk=%0b blk_cnt=%0d", rpc(), first, last, mode, junk, m_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, m_done, 1'b0);
    check({tag, "_busy"}, m_busy, 1'b0);
    check({tag, "_dout"}, m_dout, 256'h0);
    check({tag, "_cnt"}, m_cnt, 8'h0);
    check({tag, "_ready"}, m_ready, 1'b1);
  endtask

  task automatic random_messages(input int n);
    int   nb;
    logic f;
    for (int m = 0; m < n; m++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        f = (b == 0) ? 1'($urandom) : 1'($urandom_range(0, 5) == 0);
        send(rand_block(), f, b == nb - 1, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst = 1'b1; sel = 0;
    drv_valid = 1'b0; drv_first = 1'b0; drv_last = 1'b0; drv_mode = 1'b0; drv_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset1");
    sel = 1; #1;
    check_reset_outputs("reset4");
    sel = 0;
    rst = 1'b0;
    @(negedge clk);

    // ---- 1 round per cycle ----
    send(BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b0);
    check("abc256", m_dout, DIG_ABC256);
    check("abc256_cnt", m_cnt, 8'd1);
    send(BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b0);
    check("abc224", m_dout, DIG_ABC224);
    send(BLK_TWO1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(BLK_TWO2, 1'b0, 1'b1, 1'b0, 1'b0);
    check("two_block", m_dout, DIG_TWO);
    check("two_block_cnt", m_cnt, 8'd2);

    // Reset 20 cycles into a block: aborts it without a done pulse.
    drv_valid = 1'b1; drv_data = BLK_ABC; drv_first = 1'b1; drv_last = 1'b1; drv_mode = 1'b0;
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1; #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_done) ndone++;
    end
    check("midrst_nodone", ndone, 0);
    send(BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abc_after_rst", m_dout, DIG_ABC256);

    // Backpressure with garbage on the bus, then abandon the open message.
    send(rand_block(), 1'b1, 1'b0, 1'b1, 1'b1);
    send(rand_block(), 1'b0, 1'b0, 1'b0, 1'b1);
    send(BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1);
    check("abandon_abc", m_dout, DIG_ABC256);
    check("abandon_cnt", m_cnt, 8'd1);
    random_messages(8);

    // ---- 4 rounds per cycle ----
    sel = 1;
    model_reset();
    #1;
    send(BLK_EMPTY, 1'b1, 1'b1, 1'b0, 1'b0);
    check("empty4", m_dout, DIG_EMPTY);
    send(BLK_TWO1, 1'b1, 1'b0, 1'b0, 1'b1);
    send(BLK_TWO2, 1'b0, 1'b1, 1'b1, 1'b1);
    check("two_block4", m_dout, DIG_TWO);
    // Block counter saturation over a 258-block message.
    send(rand_block(), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) send(rand_block(), 1'b0, 1'b0, 1'b0, 1'b0);
    send(rand_block(), 1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_cnt", m_cnt, 8'd255);
    random_messages(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
